// File: rtl/adr_sched_pkg.sv
// -----------------------------------------------------------------------------
// adr_sched_pkg
// Shared types and constants for the 3-bit adder-slice scheduler.
//   state_t        : IDLE / RUN / DONE sequencer states
//   OWN_A / OWN_B  : owner encoding used for res_owner and the arbiter history
//   SLICE_W        : width of the external adder slice
//   owner_onehot() : owner index -> one-hot grant vector ([0]=A, [1]=B)
// Optional feature macro used by the top level: ADR_SUB_EN.
// -----------------------------------------------------------------------------
package adr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWN_A   = 1'b0;
    localparam logic OWN_B   = 1'b1;
    localparam int   SLICE_W = 3;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == OWN_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/adr_rr_arb2.sv
// -----------------------------------------------------------------------------
// adr_rr_arb2
// Two-request round-robin arbiter. Holds the last_owner history register and
// produces a combinational one-hot grant strobe while en is high.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   req[1:0]     requests, [0]=A, [1]=B
//   en           arbitration allowed (scheduler is IDLE)
//   upd          load upd_owner into the history register
//   upd_owner    owner of the operation that just completed
//   gnt[1:0]     one-hot grant strobe (0 when en is low or no request)
// -----------------------------------------------------------------------------
module adr_rr_arb2
    import adr_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       upd,
    input  logic       upd_owner,
    output logic [1:0] gnt
);

    logic last_owner_q;
    logic last_owner_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_B;   // A wins the first tie after reset
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (upd) begin
            last_owner_d = upd_owner;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Both requesting: the one that did not own the slice last
                2'b11:   gnt = (last_owner_q == OWN_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/adr_slice_sched.sv
// -----------------------------------------------------------------------------
// adr_slice_sched
// Arbitrates two requesters onto one external 3-bit ripple-carry adder and
// performs a WIDTH-bit add as WIDTH/3 sequential slices, each held on the
// adder for SETTLE clocks, with the carry chained through a register.
// Parameters: WIDTH (multiple of 3), SETTLE (>=1 clocks per slice).
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   req_a, req_b               requests (held until done)
//   a_x, a_y, a_cin            requester A operands
//   b_x, b_y, b_cin            requester B operands
//   a_sub, b_sub               subtract select (only with ADR_SUB_EN)
//   grant[1:0]                 one-hot owner while busy
//   busy, done                 operation in progress / completion pulse
//   res_sum, res_cout          result, held until the next completion
//   res_owner                  0=A, 1=B
//   adr_x, adr_y, adr_cin      slice operands to the external adder
//   adr_sum, adr_cout          slice result from the external adder
// Configuration macro: ADR_SUB_EN adds a_sub/b_sub and subtraction support.
// -----------------------------------------------------------------------------
module adr_slice_sched
    import adr_sched_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               req_b,
    input  logic [WIDTH-1:0]   a_x,
    input  logic [WIDTH-1:0]   a_y,
    input  logic [WIDTH-1:0]   b_x,
    input  logic [WIDTH-1:0]   b_y,
    input  logic               a_cin,
    input  logic               b_cin,
`ifdef ADR_SUB_EN
    input  logic               a_sub,
    input  logic               b_sub,
`endif
    output logic [1:0]         grant,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   res_sum,
    output logic               res_cout,
    output logic               res_owner,
    output logic [SLICE_W-1:0] adr_x,
    output logic [SLICE_W-1:0] adr_y,
    output logic               adr_cin,
    input  logic [SLICE_W-1:0] adr_sum,
    input  logic               adr_cout
);

    localparam int NS = WIDTH / SLICE_W;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   res_sum_q, res_sum_d;
    logic               res_cout_q, res_cout_d;
    logic               res_owner_q, res_owner_d;

    logic [1:0]         arb_gnt;
    logic               arb_upd;
    logic               sub_sel;

    logic [SLICE_W-1:0] x_sl [NS];
    logic [SLICE_W-1:0] y_sl [NS];

    for (genvar gi = 0; gi < NS; gi++) begin : g_slice
        assign x_sl[gi] = x_q[gi*SLICE_W +: SLICE_W];
        assign y_sl[gi] = y_q[gi*SLICE_W +: SLICE_W];
    end

    adr_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({req_b, req_a}),
        .en        (state_q == IDLE),
        .upd       (arb_upd),
        .upd_owner (owner_q),
        .gnt       (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            owner_q     <= OWN_A;
            x_q         <= '0;
            y_q         <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_owner_q <= OWN_A;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            x_q         <= x_d;
            y_q         <= y_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_owner_q <= res_owner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        x_d         = x_q;
        y_d         = y_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_owner_d = res_owner_q;
        arb_upd     = 1'b0;
`ifdef ADR_SUB_EN
        sub_sel     = arb_gnt[1] ? b_sub : a_sub;
`else
        sub_sel     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    owner_d = arb_gnt[1] ? OWN_B : OWN_A;
                    x_d     = arb_gnt[1] ? b_x : a_x;
                    // Subtraction is x + ~y + 1: invert y once here and seed
                    // the carry chain with 1 instead of the requester's cin.
                    y_d     = arb_gnt[1] ? b_y : a_y;
                    if (sub_sel) begin
                        y_d = ~y_d;
                    end
                    carry_d = sub_sel ? 1'b1 : (arb_gnt[1] ? b_cin : a_cin);
                    k_d     = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d = '0;
                    acc_d[int'(k_q)*SLICE_W +: SLICE_W] = adr_sum;
                    carry_d = adr_cout;
                    if (k_q == KW'(NS - 1)) begin
                        // Publish on the last capture so res_* stay stable
                        // from one completion to the next.
                        res_sum_d   = acc_d;
                        res_cout_d  = adr_cout;
                        res_owner_d = owner_q;
                        state_d     = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                arb_upd = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign grant     = busy ? owner_onehot(owner_q) : 2'b00;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_owner = res_owner_q;
    // Slice drivers come straight from registers, so they cannot move
    // during the SETTLE clocks of a slice.
    assign adr_x     = (state_q == RUN) ? x_sl[k_q] : '0;
    assign adr_y     = (state_q == RUN) ? y_sl[k_q] : '0;
    assign adr_cin   = (state_q == RUN) ? carry_q : 1'b0;

endmodule
